branch_target_buffer: RTL and testbench
=======================================

Name: branch_target_buffer

Overview:
- Direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters.
- Sits in the fetch stage and produces the prediction that the execute stage later consumes as predictedTaken.
- Consumes the execute stage's resolution interface: the update strobe, the resolved PC, the calculated jump target and the actual outcome.
- Lookup is combinational on the fetch PC. Updates are written on the clock edge.

Parameters:
- ENTRIES, 16: number of table entries; must be a power of two, minimum 2.
- IDX_W, 4: log2(ENTRIES); the index is pc[IDX_W+1:2].
- TAG_W, 26: 30-IDX_W; the tag is pc[31:IDX_W+2].

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset; asserting low clears all state immediately.
- fetch_pc  input  32  PC currently being fetched (lookup address).
- predicted_taken  output  1  lookup hit AND counter[1]==1.
- predicted_target  output  32  stored target on a taken prediction, else 32'h0.
- update_btb  input  1  execute stage resolved a branch/jump this cycle.
- update_pc  input  32  PC of the resolved instruction.
- calc_jump_addr  input  32  resolved target address.
- update_taken  input  1  actual outcome (1 = taken).
- flush  input  1  synchronous invalidate of all entries (fence.i / context change).

Behaviour:
- Per-entry state: valid (1), tag (TAG_W), target (32), ctr (2).
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Reset (rst low, asynchronous): all valid=0, ctr=00, tag=0, target=0.
  - Outputs follow combinationally: predicted_taken=0, predicted_target=0.
- Lookup (combinational, 0-cycle latency):
  - hit = valid[i] && tag[i]==fetch_pc[31:IDX_W+2].
  - predicted_taken = hit && ctr[i][1].
  - predicted_target = predicted_taken ? target[i] : 0.
- Update (rising edge, only when update_btb=1), at index j and tag from update_pc:
  - Hit, taken: ctr saturating increment (11 stays 11); target <= calc_jump_addr.
  - Hit, not taken: ctr saturating decrement (00 stays 00); target unchanged; valid stays 1.
  - Miss, taken: allocate, overwriting any alias: valid<=1, tag<=new, target<=calc_jump_addr, ctr<=10.
  - Miss, not taken: no change (no allocation on not-taken).
- Ordering and collisions:
  - Update and lookup in the same cycle to the same index: lookup returns pre-update contents; no bypass.
  - Writes are visible the cycle after the edge.
- flush=1 at an edge: all valid<=0; ctr, tag and target are don't-care.
  - flush has priority over a simultaneous update_btb; that update is dropped.
- Low update_pc[1:0] bits are ignored; no alignment check.
- Reset asserted mid-operation: state clears immediately and independently of clk.
  - The first edge after rst releases performs normal updates.
- Inputs with X on update_pc while update_btb=0 must not alter state.

Decomposition:
- Shared package, for example btb_defines alongside the existing opcode/forward defines:
  - CTR_SNT=2'b00, CTR_WNT=2'b01, CTR_WT=2'b10, CTR_ST=2'b11.
  - CTR_ALLOC=CTR_WT.
- One sub-module, btb_counter: combinational 2-bit saturating next-state function.
  - Inputs: ctr, taken. Output: ctr_next.
  - Instantiated once on the update path.
- Table storage stays in the top as register arrays so it resets asynchronously; no SRAM macro.

Test Plan (ENTRIES=16; index = pc[5:2]):
1. Release rst; fetch_pc=0x100 -> predicted_taken=0, predicted_target=0x0.
2. Update update_pc=0x100, target 0x80, taken=1. Next cycle fetch_pc=0x100 -> taken=1, target=0x80 (ctr=10).
3. From step 2, update 0x100 with taken=0 -> ctr=01; fetch 0x100 -> taken=0, target=0x0. Then update 0x100 with taken=0 three more times -> ctr stays 00. Then update 0x100 with taken=1, target 0x84 -> ctr=01, still predicts not-taken.
4. Alias on entry 0 (0x100 allocated taken, target 0x80):
   - fetch 0x140 -> taken=0.
   - Update 0x140 with taken=0 -> no allocation; fetch 0x100 still taken=1.
   - Update 0x140, target 0x200, taken=1 -> fetch 0x140 gives taken=1, target=0x200; fetch 0x100 gives taken=0.
5. Saturation and collision on 0x100 (ctr=10):
   - Three taken updates -> ctr=11; one not-taken update -> ctr=10, still taken.
   - Update 0x100 taken with target 0x90 while fetch_pc=0x100 in the same cycle -> that cycle shows the old target 0x80; the next cycle shows 0x90.
6. Reset and flush:
   - flush=1 together with update_btb=1 (0x180, taken) -> all misses after the edge, including 0x180.
   - Repopulate 0x100, then pull rst low between edges -> predicted_taken drops to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/branch_target_buffer_pkg.sv
// Shared BTB definitions: table geometry and
// 2-bit direction counter encodings.
package branch_target_buffer_pkg;

    localparam int ENTRIES = 16;
    localparam int IDX_W   = $clog2(ENTRIES);
    localparam int TAG_W   = 30 - IDX_W;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_e;

    localparam ctr_e CTR_ALLOC = CTR_WT;

endpackage

// File: rtl/branch_target_buffer_if.sv
// Fetch lookup and execute resolution bundle
// between the pipeline and the BTB.
interface branch_target_buffer_if;

    logic [31:0] fetch_pc;
    logic        predicted_taken;
    logic [31:0] predicted_target;
    logic        update_btb;
    logic [31:0] update_pc;
    logic [31:0] calc_jump_addr;
    logic        update_taken;
    logic        flush;

    modport master (
        output fetch_pc,
        output update_btb,
        output update_pc,
        output calc_jump_addr,
        output update_taken,
        output flush,
        input  predicted_taken,
        input  predicted_target
    );

    modport slave (
        input  fetch_pc,
        input  update_btb,
        input  update_pc,
        input  calc_jump_addr,
        input  update_taken,
        input  flush,
        output predicted_taken,
        output predicted_target
    );

endinterface

// File: rtl/branch_target_buffer_counter.sv
// 2-bit saturating direction counter
// next-state function.
import branch_target_buffer_pkg::*;

module branch_target_buffer_counter (
    input  logic [1:0] ctr_i,
    input  logic       taken_i,
    output logic [1:0] ctr_next_o
);

    always_comb begin
        ctr_next_o = ctr_i;
        unique case (1'b1)
            taken_i && (ctr_i != CTR_ST):   ctr_next_o = ctr_i + 2'd1;
            !taken_i && (ctr_i != CTR_SNT): ctr_next_o = ctr_i - 2'd1;
            default: ;
        endcase
    end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with
// combinational lookup and edge-written updates.
import branch_target_buffer_pkg::*;

module branch_target_buffer (
    input  logic                   clk,
    input  logic                   rst,
    branch_target_buffer_if.slave  bus
);

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_d    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [31:0]        target_d [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];
    logic [1:0]         ctr_d    [ENTRIES];

    logic [IDX_W-1:0] ridx;
    logic [TAG_W-1:0] rtag;
    logic             rhit;
    logic [IDX_W-1:0] widx;
    logic [TAG_W-1:0] wtag;
    logic             whit;
    logic [1:0]       ctr_nxt;
    logic             unused_lsb;

    assign unused_lsb = ^{bus.fetch_pc[1:0], bus.update_pc[1:0]};

    // Lookup sees pre-update contents; no write bypass.
    assign ridx = bus.fetch_pc[IDX_W+1:2];
    assign rtag = bus.fetch_pc[31:IDX_W+2];
    assign rhit = valid_q[ridx] && (tag_q[ridx] == rtag);

    assign bus.predicted_taken  = rhit && ctr_q[ridx][1];
    assign bus.predicted_target = bus.predicted_taken ? target_q[ridx] : 32'h0;

    assign widx = bus.update_pc[IDX_W+1:2];
    assign wtag = bus.update_pc[31:IDX_W+2];
    assign whit = valid_q[widx] && (tag_q[widx] == wtag);

    branch_target_buffer_counter u_ctr (
        .ctr_i      (ctr_q[widx]),
        .taken_i    (bus.update_taken),
        .ctr_next_o (ctr_nxt)
    );

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (bus.flush) begin
            valid_d = '0;
        end else if (bus.update_btb) begin
            if (whit) begin
                ctr_d[widx] = ctr_nxt;
                if (bus.update_taken)
                    target_d[widx] = bus.calc_jump_addr;
            end else if (bus.update_taken) begin
                valid_d[widx]  = 1'b1;
                tag_d[widx]    = wtag;
                target_d[widx] = bus.calc_jump_addr;
                ctr_d[widx]    = CTR_ALLOC;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_SNT;
            end
        end else begin
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            target_q <= target_d;
            ctr_q    <= ctr_d;
        end
    end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench: directed plan plus random
// traffic against a behavioural BTB model.
module tb_branch_target_buffer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    bit   chk_en = 1'b0;

    always #5 clk = ~clk;

    branch_target_buffer_if bif ();

    branch_target_buffer dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    // Model: one record per slot, keyed by (pc/4) mod 16, tag pc/64.
    bit          m_valid [16];
    int unsigned m_tag   [16];
    logic [31:0] m_tgt   [16];
    int          m_ctr   [16];

    function automatic void m_clear();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 0;
        end
    endfunction

    function automatic bit m_hit(logic [31:0] pc);
        int i = (pc / 4) % 16;
        return m_valid[i] && (m_tag[i] == pc / 64);
    endfunction

    function automatic bit m_taken(logic [31:0] pc);
        return m_hit(pc) && (m_ctr[(pc / 4) % 16] >= 2);
    endfunction

    function automatic logic [31:0] m_target(logic [31:0] pc);
        return m_taken(pc) ? m_tgt[(pc / 4) % 16] : 32'h0;
    endfunction

    function automatic void m_update(logic u, logic [31:0] pc,
                                     logic [31:0] tgt, logic tk, logic fl);
        int i = (pc / 4) % 16;
        if (fl) begin
            for (int k = 0; k < 16; k++) m_valid[k] = 0;
        end else if (u) begin
            if (m_hit(pc)) begin
                if (tk) begin
                    m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
                    m_tgt[i] = tgt;
                end else begin
                    m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
                end
            end else if (tk) begin
                m_valid[i] = 1; m_tag[i] = pc / 64;
                m_tgt[i] = tgt; m_ctr[i] = 2;
            end
        end
    endfunction

    task automatic check(string nm, logic tk, logic [31:0] tg,
                         logic etk, logic [31:0] etg);
        n_chk++;
        if (tk !== etk || tg !== etg) begin
            n_fail++;
            $display("FAIL %s: got taken=%0b target=%h, expected taken=%0b target=%h",
                     nm, tk, tg, etk, etg);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en)
            check("model", bif.predicted_taken, bif.predicted_target,
                  m_taken(bif.fetch_pc), m_target(bif.fetch_pc));
    end

    task automatic drive(logic [31:0] f, logic u, logic [31:0] upc,
                         logic [31:0] tgt, logic tk, logic fl);
        bif.fetch_pc = f; bif.update_btb = u; bif.update_pc = upc;
        bif.calc_jump_addr = tgt; bif.update_taken = tk; bif.flush = fl;
        @(posedge clk);
        if (rst) m_update(u, upc, tgt, tk, fl);
        #1;
    endtask

    task automatic upd(logic [31:0] pc, logic [31:0] tgt, logic tk);
        drive(pc, 1'b1, pc, tgt, tk, 1'b0);
    endtask

    task automatic peek(string nm, logic [31:0] pc, logic etk, logic [31:0] etg);
        bif.fetch_pc = pc; bif.update_btb = 1'b0; bif.flush = 1'b0;
        #1;
        check(nm, bif.predicted_taken, bif.predicted_target, etk, etg);
    endtask

    function automatic logic [31:0] rnd_pc();
        logic [31:0] p;
        p = {$urandom_range(0, 3), 6'b0} | ($urandom_range(0, 3) << 2)
          | $urandom_range(0, 3);
        if ($urandom_range(0, 7) == 0) p[31:28] = 4'($urandom);
        return p;
    endfunction

    initial begin
        bif.fetch_pc = 32'h100; bif.update_btb = 0; bif.update_pc = 0;
        bif.calc_jump_addr = 0; bif.update_taken = 0; bif.flush = 0;
        m_clear();
        @(posedge clk); #1;
        check("reset_out", bif.predicted_taken, bif.predicted_target, 1'b0, 32'h0);
        rst = 1'b1;
        chk_en = 1'b1;

        peek("s1_empty", 32'h100, 0, 32'h0);

        upd(32'h100, 32'h80, 1);
        peek("s2_alloc", 32'h100, 1, 32'h80);

        upd(32'h100, 32'h0, 0);
        peek("s3_wnt", 32'h100, 0, 32'h0);
        repeat (3) upd(32'h100, 32'h0, 0);
        upd(32'h100, 32'h84, 1);
        peek("s3_snt_inc", 32'h100, 0, 32'h0);

        upd(32'h100, 32'h80, 1);
        peek("s4_back_wt", 32'h100, 1, 32'h80);
        peek("s4_alias_miss", 32'h140, 0, 32'h0);
        upd(32'h140, 32'h0, 0);
        peek("s4_no_alloc", 32'h100, 1, 32'h80);
        upd(32'h140, 32'h200, 1);
        peek("s4_alias_new", 32'h140, 1, 32'h200);
        peek("s4_alias_old", 32'h100, 0, 32'h0);

        upd(32'h100, 32'h80, 1);
        repeat (3) upd(32'h100, 32'h80, 1);
        upd(32'h100, 32'h0, 0);
        peek("s5_st_dec", 32'h100, 1, 32'h80);

        bif.fetch_pc = 32'h100; bif.update_btb = 1; bif.update_pc = 32'h100;
        bif.calc_jump_addr = 32'h90; bif.update_taken = 1; bif.flush = 0;
        #1;
        check("s5_collide_old", bif.predicted_taken, bif.predicted_target, 1, 32'h80);
        @(posedge clk);
        m_update(1, 32'h100, 32'h90, 1, 0);
        #1;
        peek("s5_collide_new", 32'h100, 1, 32'h90);

        drive(32'h180, 1, 32'h180, 32'h300, 1, 1);
        peek("s6_flush_upd", 32'h180, 0, 32'h0);
        peek("s6_flush_old", 32'h100, 0, 32'h0);

        upd(32'h100, 32'h80, 1);
        peek("s6_repop", 32'h100, 1, 32'h80);
        rst = 1'b0;
        m_clear();
        #1;
        check("s6_async_rst", bif.predicted_taken, bif.predicted_target, 0, 32'h0);
        upd(32'h100, 32'h88, 1);
        rst = 1'b1;
        peek("s6_rst_held", 32'h100, 0, 32'h0);
        upd(32'h100, 32'h88, 1);
        peek("s6_after_rel", 32'h100, 1, 32'h88);

        for (int n = 0; n < 3000; n++) begin
            logic [31:0] p;
            p = rnd_pc();
            drive($urandom_range(0, 1) ? p : rnd_pc(),
                  1'($urandom_range(0, 1)), p, $urandom & 32'hffff_fffc,
                  1'($urandom_range(0, 2) != 0), $urandom_range(0, 60) == 0);
        end

        bif.update_btb = 0; bif.flush = 0;
        @(negedge clk); #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
